// File: rtl/ex_muldiv_unit.sv
// Multi-cycle RV32M multiply/divide unit for the EX stage: radix-2 shift-add multiply and restoring divide.
// Optional MDU_FAST_SPECIAL_EN retires divide-by-zero, signed overflow and zero-operand multiplies directly.
module ex_muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            StartE,
    input  logic            FlushE,
    input  logic [2:0]      funct3E,
    input  logic [XLEN-1:0] SrcAE,
    input  logic [XLEN-1:0] SrcBE,
    output logic            BusyE,
    output logic            DoneE,
    output logic [XLEN-1:0] MDResultE
);

    localparam int              CW       = $clog2(XLEN);
    localparam logic [CW-1:0]   LAST_CNT = CW'(XLEN - 1);
    localparam logic [CW-1:0]   CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [XLEN-1:0] ZERO     = {XLEN{1'b0}};
    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [XLEN-1:0] cond_neg(input logic neg, input logic [XLEN-1:0] v);
        return neg ? (~v + {{(XLEN-1){1'b0}}, 1'b1}) : v;
    endfunction

    state_t          state_r;
    logic [CW-1:0]   cnt_r;
    logic [XLEN-1:0] hi_r, lo_r, op_r, special_val_r;
    logic [2:0]      fn_r;
    logic            neg_r, special_r;

    logic            a_signed_s, b_signed_s, a_neg_s, b_neg_s, neg_s, special_s;
    logic [XLEN-1:0] a_mag_s, b_mag_s, special_val_s;
    logic [XLEN:0]   mul_sum_s, div_shift_s, div_diff_s;
    logic [XLEN-1:0] hi_nxt_s, lo_nxt_s, result_s;
    logic [2*XLEN-1:0] prod_s;

    // Operand decode at issue: signedness, magnitudes, result sign and special-case detection
    always_comb begin
        a_signed_s = 1'b0;
        b_signed_s = 1'b0;
        case (funct3E)
            3'b001, 3'b100, 3'b110: begin
                a_signed_s = 1'b1;
                b_signed_s = 1'b1;
            end
            3'b010:  a_signed_s = 1'b1;
            default: begin
                a_signed_s = 1'b0;
                b_signed_s = 1'b0;
            end
        endcase
        a_neg_s = a_signed_s & SrcAE[XLEN-1];
        b_neg_s = b_signed_s & SrcBE[XLEN-1];
        a_mag_s = cond_neg(a_neg_s, SrcAE);
        b_mag_s = cond_neg(b_neg_s, SrcBE);
        // Remainder takes the dividend's sign; everything else takes the product sign
        if (funct3E[2] && funct3E[1]) begin
            neg_s = a_neg_s;
        end else begin
            neg_s = a_neg_s ^ b_neg_s;
        end
        special_s     = 1'b0;
        special_val_s = ZERO;
        if (funct3E[2]) begin
            if (SrcBE == ZERO) begin
                special_s     = 1'b1;
                special_val_s = funct3E[1] ? SrcAE : ALL_ONES;
            end else if (!funct3E[0] && (SrcAE == MIN_NEG) && (SrcBE == ALL_ONES)) begin
                special_s     = 1'b1;
                special_val_s = funct3E[1] ? ZERO : MIN_NEG;
            end else begin
                special_s     = 1'b0;
                special_val_s = ZERO;
            end
        end else if ((SrcAE == ZERO) || (SrcBE == ZERO)) begin
            special_s     = 1'b1;
            special_val_s = ZERO;
        end else begin
            special_s     = 1'b0;
            special_val_s = ZERO;
        end
    end

    // One radix-2 iteration plus final sign correction and result selection
    always_comb begin
        mul_sum_s   = {1'b0, hi_r} + (lo_r[0] ? {1'b0, op_r} : {(XLEN+1){1'b0}});
        div_shift_s = {hi_r, lo_r[XLEN-1]};
        div_diff_s  = div_shift_s - {1'b0, op_r};
        if (fn_r[2]) begin
            if (!div_diff_s[XLEN]) begin
                hi_nxt_s = div_diff_s[XLEN-1:0];
                lo_nxt_s = {lo_r[XLEN-2:0], 1'b1};
            end else begin
                hi_nxt_s = div_shift_s[XLEN-1:0];
                lo_nxt_s = {lo_r[XLEN-2:0], 1'b0};
            end
        end else begin
            hi_nxt_s = mul_sum_s[XLEN:1];
            lo_nxt_s = {mul_sum_s[0], lo_r[XLEN-1:1]};
        end
        prod_s = neg_r ? (~{hi_nxt_s, lo_nxt_s} + {{(2*XLEN-1){1'b0}}, 1'b1})
                       : {hi_nxt_s, lo_nxt_s};
        if (special_r) begin
            result_s = special_val_r;
        end else if (fn_r[2]) begin
            result_s = cond_neg(neg_r, fn_r[1] ? hi_nxt_s : lo_nxt_s);
        end else if (fn_r[1:0] == 2'b00) begin
            result_s = prod_s[XLEN-1:0];
        end else begin
            result_s = prod_s[2*XLEN-1:XLEN];
        end
    end

    // Stall request: the issuing instruction is held from the cycle it presents StartE
    always_comb begin
        if (state_r == CALC) begin
            BusyE = 1'b1;
        end else if (state_r == IDLE) begin
            BusyE = StartE;
        end else begin
            BusyE = 1'b0;
        end
    end

    // Control FSM with iterative datapath and registered result outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= IDLE;
            cnt_r         <= {CW{1'b0}};
            hi_r          <= ZERO;
            lo_r          <= ZERO;
            op_r          <= ZERO;
            special_val_r <= ZERO;
            fn_r          <= 3'b000;
            neg_r         <= 1'b0;
            special_r     <= 1'b0;
            DoneE         <= 1'b0;
            MDResultE     <= ZERO;
        end else begin
            DoneE <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (FlushE) begin
                        state_r <= IDLE;
                    end else if (StartE) begin
                        fn_r          <= funct3E;
                        neg_r         <= neg_s;
                        special_r     <= special_s;
                        special_val_r <= special_val_s;
                        hi_r          <= ZERO;
                        lo_r          <= funct3E[2] ? a_mag_s : b_mag_s;
                        op_r          <= funct3E[2] ? b_mag_s : a_mag_s;
                        cnt_r         <= {CW{1'b0}};
`ifdef MDU_FAST_SPECIAL_EN
                        if (special_s) begin
                            MDResultE <= special_val_s;
                            DoneE     <= 1'b1;
                            state_r   <= DONE;
                        end else begin
                            state_r <= CALC;
                        end
`else
                        state_r <= CALC;
`endif
                    end else begin
                        state_r <= IDLE;
                    end
                end
                CALC: begin
                    if (FlushE) begin
                        state_r <= IDLE;
                    end else begin
                        hi_r <= hi_nxt_s;
                        lo_r <= lo_nxt_s;
                        if (cnt_r == LAST_CNT) begin
                            MDResultE <= result_s;
                            DoneE     <= 1'b1;
                            state_r   <= DONE;
                        end else begin
                            cnt_r <= cnt_r + CNT_ONE;
                        end
                    end
                end
                DONE:    state_r <= IDLE;
                default: state_r <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed vector table, randomized ops against a
// plain-arithmetic RV32M model, and hand-written flush / start+flush / async-reset sequences.
module tb_ex_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n, StartE, FlushE;
    logic [2:0]  funct3E;
    logic [31:0] SrcAE, SrcBE;
    logic        BusyE, DoneE;
    logic [31:0] MDResultE;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[16];

    always #5 clk = ~clk;

    ex_muldiv_unit #(.XLEN(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .StartE    (StartE),
        .FlushE    (FlushE),
        .funct3E   (funct3E),
        .SrcAE     (SrcAE),
        .SrcBE     (SrcBE),
        .BusyE     (BusyE),
        .DoneE     (DoneE),
        .MDResultE (MDResultE)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%h required=%h", nm, act, exp);
        end
    endtask

    // RV32M semantics from 64-bit integer arithmetic
    function automatic logic [31:0] ref_md(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, p;
        longint unsigned ua, ub, up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (f)
            3'd0: begin up = ua * ub; return up[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'(ub); return p[63:32]; end
            3'd3: begin up = ua * ub; return up[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                p = sa / sb;
                return p[31:0];
            end
            3'd5: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                p = sa % sb;
                return p[31:0];
            end
            default: begin
                if (b == 32'd0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
`ifdef MDU_FAST_SPECIAL_EN
        bit sp;
        sp = (f[2] && b == 32'd0) ||
             ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ||
             (!f[2] && (a == 32'd0 || b == 32'd0));
        if (sp) return 1;
`endif
        return 33;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Issue one op, follow it to its DoneE pulse, check latency, stall and result
    task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input bit keep_start, input string nm);
        int lat, cyc, busy_bad;
        bit got;
        lat = exp_lat(f, a, b);
        @(negedge clk);
        StartE = 1'b1; funct3E = f; SrcAE = a; SrcBE = b;
        #1 chk({nm, "/busy_issue"}, 32'(BusyE), 32'd1);
        @(negedge clk);
        StartE = keep_start; SrcAE = $urandom; SrcBE = $urandom; funct3E = 3'($urandom_range(0, 7));
        cyc = 1; busy_bad = 0; got = 1'b0;
        while (!got && cyc <= 100) begin
            #1;
            if (DoneE) begin
                got = 1'b1;
            end else begin
                if (BusyE !== 1'b1) busy_bad++;
                cyc++;
                @(negedge clk);
            end
        end
        if (!got) begin
            chk({nm, "/timeout"}, 32'd0, 32'd1);
        end else begin
            chk({nm, "/latency"}, 32'(cyc), 32'(lat));
            chk({nm, "/result"}, MDResultE, exp);
            chk({nm, "/busy_done"}, 32'(BusyE), 32'd0);
            chk({nm, "/busy_calc"}, 32'(busy_bad), 32'd0);
        end
        StartE = 1'b0;
        @(negedge clk);
        #1;
        chk({nm, "/done_pulse"}, 32'(DoneE), 32'd0);
        chk({nm, "/hold"}, MDResultE, exp);
    endtask

    initial begin
        logic [2:0]  rf;
        logic [31:0] ra, rb;
        bit          done_seen;

        vecs[0]  = '{3'd0, 32'd7,          32'd6,          32'h0000_002A};
        vecs[1]  = '{3'd1, 32'h8000_0000,  32'h8000_0000,  32'h4000_0000};
        vecs[2]  = '{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFF};
        vecs[3]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE};
        vecs[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD};
        vecs[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF};
        vecs[6]  = '{3'd5, 32'd100,        32'd7,          32'd14};
        vecs[7]  = '{3'd7, 32'd100,        32'd7,          32'd2};
        vecs[8]  = '{3'd5, 32'd5,          32'd0,          32'hFFFF_FFFF};
        vecs[9]  = '{3'd6, 32'd5,          32'd0,          32'd5};
        vecs[10] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000};
        vecs[11] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0};
        vecs[12] = '{3'd4, 32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFFF};
        vecs[13] = '{3'd6, 32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFF9};
        vecs[14] = '{3'd0, 32'd0,          32'h1234_5678,  32'd0};
        vecs[15] = '{3'd1, 32'hFFFF_FFFE,  32'd3,          32'hFFFF_FFFF};

        rst_n = 1'b0; StartE = 1'b0; FlushE = 1'b0; funct3E = 3'd0; SrcAE = 32'd0; SrcBE = 32'd0;
        #12;
        chk("reset/busy", 32'(BusyE), 32'd0);
        chk("reset/done", 32'(DoneE), 32'd0);
        chk("reset/result", MDResultE, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            do_op(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].exp, 1'b0, $sformatf("vec%0d", i));
        end

        for (int i = 0; i < 40; i++) begin
            rf = 3'($urandom_range(0, 7));
            ra = pick_operand();
            rb = pick_operand();
            do_op(rf, ra, rb, ref_md(rf, ra, rb), ($urandom_range(0, 3) == 0), $sformatf("rnd%0d", i));
        end

        // Flush at cycle 10 of a MUL: stall drops next cycle, no pulse, result kept
        do_op(3'd0, 32'd7, 32'd6, 32'h2A, 1'b0, "pre_flush");
        @(negedge clk);
        StartE = 1'b1; funct3E = 3'd0; SrcAE = 32'd3; SrcBE = 32'd3;
        @(negedge clk);
        StartE = 1'b0;
        for (int c = 1; c < 10; c++) @(negedge clk);
        FlushE = 1'b1;
        @(negedge clk);
        FlushE = 1'b0;
        #1 chk("flush/busy", 32'(BusyE), 32'd0);
        done_seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            #1 if (DoneE) done_seen = 1'b1;
        end
        chk("flush/no_done", 32'(done_seen), 32'd0);
        chk("flush/hold", MDResultE, 32'h2A);

        // StartE with FlushE in IDLE must not be accepted
        @(negedge clk);
        StartE = 1'b1; FlushE = 1'b1; funct3E = 3'd0; SrcAE = 32'd5; SrcBE = 32'd5;
        @(negedge clk);
        StartE = 1'b0; FlushE = 1'b0;
        #1 chk("startflush/busy", 32'(BusyE), 32'd0);
        done_seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            #1 if (DoneE) done_seen = 1'b1;
        end
        chk("startflush/no_done", 32'(done_seen), 32'd0);
        chk("startflush/hold", MDResultE, 32'h2A);

        // Asynchronous reset in the middle of a DIV
        do_op(3'd5, 32'd100, 32'd7, 32'd14, 1'b0, "pre_reset");
        @(negedge clk);
        StartE = 1'b1; funct3E = 3'd4; SrcAE = 32'd1000; SrcBE = 32'd7;
        @(negedge clk);
        StartE = 1'b0;
        for (int c = 1; c < 15; c++) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("areset/busy", 32'(BusyE), 32'd0);
        chk("areset/done", 32'(DoneE), 32'd0);
        chk("areset/result", MDResultE, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("post_reset/busy", 32'(BusyE), 32'd0);
        chk("post_reset/result", MDResultE, 32'd0);
        do_op(3'd0, 32'd2, 32'd3, 32'd6, 1'b0, "post_reset_mul");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- Multi-cycle RV32M multiply/divide unit in the EX stage, alongside the single-cycle ALU.
- Takes the same forwarded operands (SrcAE, SrcBE) and funct3E, but computes over many cycles.
- Drives a stall request back to the hazard unit and returns a one-cycle-valid result that EX muxes onto ALUResultE.
- Radix-2 iterative datapath: shift-add multiply, restoring divide; one bit per cycle.

Parameters:
- XLEN, 32, operand/result width; power of two, 8 or greater; iteration count equals XLEN.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- StartE  input  1  request new operation; sampled only in IDLE
- FlushE  input  1  abort in-flight operation (branch mispredict/trap)
- funct3E  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- SrcAE  input  XLEN  rs1 operand (dividend/multiplicand)
- SrcBE  input  XLEN  rs2 operand (divisor/multiplier)
- BusyE  output  1  stall request; high while operation in progress
- DoneE  output  1  one-cycle pulse; MDResultE valid
- MDResultE  output  XLEN  result; held until next accepted StartE

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - BusyE=0, DoneE=0, MDResultE=0.
  - Counter and internal registers cleared.
  - Reset mid-operation discards it; no DoneE.
- States: IDLE, CALC, DONE.
- IDLE:
  - StartE=1 && FlushE=0 at an edge: latch SrcAE, SrcBE, funct3E; take magnitudes for signed ops; record result sign; counter=0; go to CALC.
  - Operands/funct3E are don't-care after the accepting edge.
- CALC:
  - One iteration per cycle, counter increments.
  - After iteration XLEN-1: sign-correct and write MDResultE, go to DONE.
- DONE: DoneE=1 for exactly one cycle, then IDLE.
  - StartE in DONE is ignored.
  - Back-to-back ops need StartE re-asserted in IDLE.
- BusyE:
  - BusyE=1 in CALC, and combinationally in IDLE when StartE=1 (stalls the issuing instruction immediately).
  - BusyE=0 in DONE, so the pipeline advances and captures MDResultE that cycle.
- Latency: accepting edge at cycle 0; DoneE high during cycle XLEN+1 (33 for XLEN=32).
- StartE while in CALC/DONE: ignored.
- FlushE:
  - FlushE=1 in any state: next edge goes to IDLE.
  - Suppresses the DONE pulse; MDResultE is not updated.
  - FlushE and StartE together in IDLE: flush wins, no operation accepted.
- Multiply result selection:
  - Full 2*XLEN product.
  - MUL returns the low half; MULH/MULHSU/MULHU return the high half.
  - Signedness: MULH signed×signed, MULHSU signed×unsigned, MULHU unsigned×unsigned.
- Divide:
  - DIV/REM: truncate toward zero; remainder sign equals dividend sign.
  - DIVU/REMU: unsigned.
- Divide by zero:
  - Quotient=all ones (DIV and DIVU).
  - Remainder=dividend.
- Signed overflow (0x80000000 / 0xFFFFFFFF): quotient=0x80000000, remainder=0.
- Special cases follow normal timing unless the optional feature is compiled in.

Optional Feature:
- Macro: MDU_FAST_SPECIAL_EN.
- Defined: the following go IDLE→DONE directly (DoneE in cycle 1 after accept, BusyE high only in the accept cycle):
  - divide-by-zero;
  - signed overflow;
  - multiply with either operand zero.
- Not defined: all operations take the full XLEN+1 latency; results are identical either way.

Test Plan:
- MUL, A=7, B=6, StartE pulse -> BusyE high for 32 cycles, DoneE in cycle 33, MDResultE=0x0000002A.
- MULH A=0x80000000, B=0x80000000 -> 0x40000000; MULHSU A=0xFFFFFFFF, B=0xFFFFFFFF -> 0xFFFFFFFF; MULHU same operands -> 0xFFFFFFFE.
- DIV A=0xFFFFFFF9 (-7), B=2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU A=100, B=7 -> 14; REMU -> 2.
- DIVU A=5, B=0 -> 0xFFFFFFFF; REM A=5, B=0 -> 5; DIV A=0x80000000, B=0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
  - With MDU_FAST_SPECIAL_EN: DoneE in cycle 1 for these cases.
  - Without it: DoneE in cycle 33.
- MUL 3×3, then FlushE=1 at cycle 10 -> BusyE low from cycle 11, no DoneE, MDResultE keeps prior value.
  - StartE+FlushE together in IDLE -> no accept.
- rst_n low at cycle 15 of a DIV -> BusyE, DoneE, MDResultE=0 immediately (asynchronous).
  - After release, a new MUL 2×3 -> 6 at cycle 33.
